// File: rtl/cache_memory_nway.sv
// N-way set-associative tag/data store with per-set tree-PLRU replacement and a
// self-sequenced flush engine that writes back dirty lines over a valid/ready port.
//
// state | meaning
// IDLE  | serving cache requests, waiting for flush_req
// SCAN  | examining line {set,way} = scan_cnt
// WB    | dirty line presented on wb_valid until wb_ready
// DONE  | flush_done pulse, back to IDLE next cycle
module cache_memory_nway #(
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_BLOCKS      = 64,
  parameter int NUM_WAYS        = 4,
  parameter int TAG_WIDTH       = 25,
  localparam int OFFSET_WIDTH   = $clog2(WORDS_PER_BLOCK),
  localparam int NUM_SETS       = NUM_BLOCKS / NUM_WAYS,
  localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
  localparam int WAY_WIDTH      = $clog2(NUM_WAYS),
  localparam int BLOCK_SIZE     = WORD_SIZE * WORDS_PER_BLOCK
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TAG_WIDTH-1:0]    tag,
  input  logic [INDEX_WIDTH-1:0]  index,
  input  logic [OFFSET_WIDTH-1:0] blk_offset,
  input  logic                    req_type,
  input  logic                    read_en_cache,
  input  logic                    write_en_cache,
  input  logic                    read_en_mem,
  input  logic                    write_en_mem,
  input  logic [BLOCK_SIZE-1:0]   data_in_mem,
  input  logic [WORD_SIZE-1:0]    data_in,
  input  logic                    flush_req,
  input  logic                    wb_ready,
  output logic                    hit,
  output logic [WAY_WIDTH-1:0]    hit_way,
  output logic [WORD_SIZE-1:0]    data_out,
  output logic                    dirty_bit,
  output logic [BLOCK_SIZE-1:0]   dirty_block_out,
  output logic [TAG_WIDTH-1:0]    dirty_tag_out,
  output logic                    wb_valid,
  output logic                    flush_busy,
  output logic                    flush_done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB, S_DONE} flush_state_t;
  flush_state_t state;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  // PLRU tree in bits [NUM_WAYS-2:0]; the top bit is padding and stays 0
  logic [NUM_WAYS-1:0]   plru_q  [NUM_SETS];
  logic [TAG_WIDTH-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [BLOCK_SIZE-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic [INDEX_WIDTH+WAY_WIDTH-1:0] scan_cnt;
  logic [INDEX_WIDTH-1:0]           scan_set;
  logic [WAY_WIDTH-1:0]             scan_way;
  assign scan_set = scan_cnt[INDEX_WIDTH+WAY_WIDTH-1:WAY_WIDTH];
  assign scan_way = scan_cnt[WAY_WIDTH-1:0];

  logic [WAY_WIDTH-1:0]  inv_way, plru_way, victim_way, use_way, uw;
  logic                  inv_found;
  logic [NUM_WAYS-1:0]   plru_cur, plru_next;
  logic [WAY_WIDTH-1:0]  node, unode;
  logic                  ub;
  logic [BLOCK_SIZE-1:0] refill_line, victim_blk_q;
  logic [TAG_WIDTH-1:0]  victim_tag_q;
  logic                  req_ok, rd_hit, wr_hit, do_refill, touch;

  // descending scans so the lowest-numbered way wins
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (!flush_busy && valid_q[index][w] && tag_q[index][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!valid_q[index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_WIDTH'(w);
      end
    end
  end

  always_comb begin
    plru_cur = plru_q[index];
    node     = '0;
    plru_way = '0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      plru_way = (plru_way << 1) | WAY_WIDTH'(plru_cur[node]);
      node     = (node << 1) + WAY_WIDTH'(1) + WAY_WIDTH'(plru_cur[node]);
    end
  end

  assign victim_way = inv_found ? inv_way : plru_way;
  assign use_way    = hit ? hit_way : victim_way;

  // each node on the path to use_way is pointed at the opposite subtree
  always_comb begin
    plru_next = plru_q[index];
    unode     = '0;
    uw        = use_way;
    ub        = 1'b0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      ub               = uw[WAY_WIDTH-1];
      plru_next[unode] = ~ub;
      unode            = (unode << 1) + WAY_WIDTH'(1) + WAY_WIDTH'(ub);
      uw               = uw << 1;
    end
  end

  always_comb begin
    refill_line = data_in_mem;
    if (req_type)
      refill_line[blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
  end

  assign req_ok    = !flush_busy && !write_en_mem;
  assign rd_hit    = req_ok && read_en_cache && hit;
  assign wr_hit    = req_ok && write_en_cache && req_type && hit;
  assign do_refill = req_ok && write_en_cache && read_en_mem && !hit;
  assign touch     = rd_hit || (req_ok && write_en_cache && hit) || do_refill;

  assign dirty_bit = valid_q[index][victim_way] && dirty_q[index][victim_way];

  always_comb begin
    if (flush_busy) begin
      dirty_block_out = data_q[scan_set][scan_way];
      dirty_tag_out   = tag_q[scan_set][scan_way];
    end else if (write_en_mem) begin
      dirty_block_out = victim_blk_q;
      dirty_tag_out   = victim_tag_q;
    end else begin
      dirty_block_out = data_q[index][victim_way];
      dirty_tag_out   = tag_q[index][victim_way];
    end
  end

  // tags and line data carry no reset
  always_ff @(posedge clk) begin
    if (do_refill) begin
      tag_q[index][victim_way]  <= tag;
      data_q[index][victim_way] <= refill_line;
    end else if (wr_hit) begin
      data_q[index][hit_way][blk_offset*WORD_SIZE +: WORD_SIZE] <= data_in;
    end
    if (!write_en_mem) begin
      victim_blk_q <= data_q[index][victim_way];
      victim_tag_q <= tag_q[index][victim_way];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      data_out   <= '0;
      state      <= S_IDLE;
      scan_cnt   <= '0;
      wb_valid   <= 1'b0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      if (rd_hit)
        data_out <= data_q[index][hit_way][blk_offset*WORD_SIZE +: WORD_SIZE];
      if (touch)
        plru_q[index] <= plru_next;
      if (do_refill) begin
        valid_q[index][victim_way] <= 1'b1;
        dirty_q[index][victim_way] <= req_type;
      end else if (wr_hit) begin
        dirty_q[index][hit_way] <= 1'b1;
      end

      flush_done <= 1'b0;
      case (state)
        S_IDLE: if (flush_req) begin
          state      <= S_SCAN;
          flush_busy <= 1'b1;
          scan_cnt   <= '0;
        end
        S_SCAN: if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
          state    <= S_WB;
          wb_valid <= 1'b1;
        end else begin
          valid_q[scan_set][scan_way] <= 1'b0;
          dirty_q[scan_set][scan_way] <= 1'b0;
          scan_cnt <= scan_cnt + 1'b1;
          if (&scan_cnt) begin
            state      <= S_DONE;
            flush_done <= 1'b1;
          end
        end
        S_WB: if (wb_ready) begin
          valid_q[scan_set][scan_way] <= 1'b0;
          dirty_q[scan_set][scan_way] <= 1'b0;
          wb_valid <= 1'b0;
          scan_cnt <= scan_cnt + 1'b1;
          if (&scan_cnt) begin
            state      <= S_DONE;
            flush_done <= 1'b1;
          end else begin
            state <= S_SCAN;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          flush_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_memory_nway.sv
// Scoreboard bench for cache_memory_nway (4 ways, 16 sets): read data and flush
// write-backs are queued at stimulus time and compared when the DUT produces them.
module tb_cache_memory_nway;
  logic          clk;
  logic          rst;
  logic [24:0]   tag;
  logic [3:0]    index;
  logic [1:0]    blk_offset;
  logic          req_type, read_en_cache, write_en_cache, read_en_mem, write_en_mem;
  logic [127:0]  data_in_mem;
  logic [31:0]   data_in;
  logic          flush_req, wb_ready;
  logic          hit;
  logic [1:0]    hit_way;
  logic [31:0]   data_out;
  logic          dirty_bit;
  logic [127:0]  dirty_block_out;
  logic [24:0]   dirty_tag_out;
  logic          wb_valid, flush_busy, flush_done;

  cache_memory_nway dut (
    .clk(clk), .rst(rst), .tag(tag), .index(index), .blk_offset(blk_offset),
    .req_type(req_type), .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .read_en_mem(read_en_mem), .write_en_mem(write_en_mem), .data_in_mem(data_in_mem),
    .data_in(data_in), .flush_req(flush_req), .wb_ready(wb_ready), .hit(hit),
    .hit_way(hit_way), .data_out(data_out), .dirty_bit(dirty_bit),
    .dirty_block_out(dirty_block_out), .dirty_tag_out(dirty_tag_out),
    .wb_valid(wb_valid), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0]  tag;
    logic [127:0] blk;
  } wb_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rd_q[$];
  wb_t         wb_q[$];
  wb_t         e;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    read_en_mem    = 1'b0;
    write_en_mem   = 1'b0;
    req_type       = 1'b0;
    flush_req      = 1'b0;
  endtask

  task automatic refill(input logic [3:0] s, input logic [24:0] t, input logic [127:0] line,
                        input logic wr, input logic [1:0] off, input logic [31:0] din);
    index = s; tag = t; data_in_mem = line; req_type = wr; blk_offset = off; data_in = din;
    write_en_cache = 1'b1;
    read_en_mem    = 1'b1;
    #1;
    check("refill_miss", hit, 1'b0);
    tick();
    clear_in();
  endtask

  task automatic read_word(input string name, input logic [3:0] s, input logic [24:0] t,
                           input logic [1:0] off, input logic [1:0] exp_way,
                           input logic [31:0] exp_data);
    index = s; tag = t; blk_offset = off; req_type = 1'b0;
    read_en_cache = 1'b1;
    #1;
    check({name, "_hit"}, hit, 1'b1);
    check({name, "_way"}, hit_way, exp_way);
    rd_q.push_back(exp_data);
    tick();
    read_en_cache = 1'b0;
    check(name, data_out, rd_q.pop_front());
  endtask

  task automatic expect_miss(input string name, input logic [3:0] s, input logic [24:0] t);
    index = s; tag = t;
    #1;
    check(name, hit, 1'b0);
  endtask

  logic [127:0] l1, l2, m, a, b, c, blk_new;
  logic [127:0] snap_blk;
  logic [24:0]  snap_tag;
  int           cyc, hs, dones, stall;

  initial begin
    rst = 1'b1; tag = '0; index = '0; blk_offset = '0; data_in_mem = '0; data_in = '0;
    wb_ready = 1'b0;
    clear_in();
    repeat (2) tick();
    rst = 1'b0;

    // reset state
    check("rst_data_out", data_out, 32'h0);
    check("rst_busy", flush_busy, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_done", flush_done, 1'b0);
    index = 4'd0; tag = 25'h1ABCDE;
    #1;
    check("rst_hit", hit, 1'b0);
    check("rst_dirty_bit", dirty_bit, 1'b0);

    // refill + read hit
    l1 = {32'hDEADBEEF, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    l2 = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    refill(4'd0, 25'h1ABCDE, l1, 1'b0, 2'd0, 32'h0);
    refill(4'd0, 25'h1ABBDE, l2, 1'b0, 2'd0, 32'h0);
    read_word("t1_rd", 4'd0, 25'h1ABCDE, 2'd3, 2'd0, 32'hDEADBEEF);
    read_word("t1_rd_w1", 4'd0, 25'h1ABBDE, 2'd0, 2'd1, 32'hCAFE0000);

    // write hit, then simultaneous read+write returns pre-write word
    index = 4'd0; tag = 25'h1ABCDE; blk_offset = 2'd2; data_in = 32'hACF0359E;
    req_type = 1'b1; write_en_cache = 1'b1;
    #1;
    check("t2_wr_hit", hit, 1'b1);
    tick();
    clear_in();
    read_word("t2_rd", 4'd0, 25'h1ABCDE, 2'd2, 2'd0, 32'hACF0359E);
    index = 4'd0; tag = 25'h1ABCDE; blk_offset = 2'd1; data_in = 32'h5A5A5A5A;
    req_type = 1'b1; write_en_cache = 1'b1; read_en_cache = 1'b1;
    rd_q.push_back(32'hB1B1B1B1);
    tick();
    clear_in();
    check("t2_rw_pre", data_out, rd_q.pop_front());
    read_word("t2_rw_post", 4'd0, 25'h1ABCDE, 2'd1, 2'd0, 32'h5A5A5A5A);

    // fill set3, access 2,0,1 -> PLRU victim is way3
    for (int w = 0; w < 4; w++)
      refill(4'd3, 25'h100 + 25'(w), {4{32'h30000000 + 32'(w)}}, 1'b0, 2'd0, 32'h0);
    read_word("t3_rd_w2", 4'd3, 25'h102, 2'd0, 2'd2, 32'h30000002);
    read_word("t3_rd_w0", 4'd3, 25'h100, 2'd0, 2'd0, 32'h30000000);
    read_word("t3_rd_w1", 4'd3, 25'h101, 2'd0, 2'd1, 32'h30000001);
    index = 4'd3;
    #1;
    check("t3_dirty_bit", dirty_bit, 1'b0);
    check("t3_victim_tag", dirty_tag_out, 25'h103);
    check("t3_victim_blk", dirty_block_out, {4{32'h30000003}});
    refill(4'd3, 25'h0BEEF, 128'h112233445566778899AABBCCDDEEFF00, 1'b0, 2'd0, 32'h0);
    read_word("t3_new_w0", 4'd3, 25'h0BEEF, 2'd0, 2'd3, 32'hDDEEFF00);
    read_word("t3_new_w3", 4'd3, 25'h0BEEF, 2'd3, 2'd3, 32'h11223344);
    expect_miss("t3_evicted", 4'd3, 25'h103);

    // write_en_mem freezes victim outputs and blocks array updates
    index = 4'd3;
    tick();
    index = 4'd5; tag = 25'h0CAFE; data_in_mem = '1;
    write_en_mem = 1'b1; write_en_cache = 1'b1; read_en_mem = 1'b1;
    #1;
    check("frz_tag_held", dirty_tag_out, 25'h100);
    tick();
    clear_in();
    expect_miss("frz_no_refill", 4'd5, 25'h0CAFE);

    // write-allocate miss, then dirty victim seen once the set is full
    m = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
    refill(4'd2, 25'h201, m, 1'b1, 2'd0, 32'h12345678);
    read_word("t4_w0", 4'd2, 25'h201, 2'd0, 2'd0, 32'h12345678);
    read_word("t4_w1", 4'd2, 25'h201, 2'd1, 2'd0, 32'h44440001);
    for (int w = 1; w < 4; w++)
      refill(4'd2, 25'h201 + 25'(w), {4{32'h20000000 + 32'(w)}}, 1'b0, 2'd0, 32'h0);
    index = 4'd2;
    #1;
    check("t4_dirty_bit", dirty_bit, 1'b1);
    check("t4_dirty_tag", dirty_tag_out, 25'h201);
    check("t4_dirty_blk", dirty_block_out, {m[127:32], 32'h12345678});

    // flush with two dirty lines and a stalled first handshake
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a = {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
    b = {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000};
    c = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
    refill(4'd0, 25'h0AAAA, a, 1'b1, 2'd0, 32'hA0A0A0A0);
    e.tag = 25'h0AAAA; e.blk = {a[127:32], 32'hA0A0A0A0};
    wb_q.push_back(e);
    refill(4'd5, 25'h05550, c, 1'b0, 2'd0, 32'h0);
    refill(4'd5, 25'h05551, b, 1'b1, 2'd2, 32'hB2B2B2B2);
    blk_new = {b[127:96], 32'hB2B2B2B2, b[63:0]};
    e.tag = 25'h05551; e.blk = blk_new;
    wb_q.push_back(e);
    refill(4'd7, 25'h07770, c, 1'b0, 2'd0, 32'h0);
    index = 4'd5; tag = 25'h05551;
    #1;
    check("t5_pre_hit", hit, 1'b1);
    check("t5_pre_way", hit_way, 2'd1);

    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("t5_busy", flush_busy, 1'b1);
    index = 4'd0; tag = 25'h0AAAA; read_en_cache = 1'b1;
    #1;
    check("t5_hit_masked", hit, 1'b0);
    read_en_cache = 1'b0;
    cyc = 0; hs = 0; dones = 0; stall = 0;
    while (flush_busy && cyc < 400) begin
      if (flush_done) dones++;
      if (wb_valid) begin
        if (hs == 0 && stall < 3) begin
          wb_ready = 1'b0;
          if (stall == 0) begin
            snap_blk = dirty_block_out;
            snap_tag = dirty_tag_out;
          end else begin
            check("t5_stable_blk", dirty_block_out, snap_blk);
            check("t5_stable_tag", dirty_tag_out, snap_tag);
          end
          stall++;
        end else begin
          wb_ready = 1'b1;
          check("t5_wb_expected", wb_q.size() != 0, 1'b1);
          if (wb_q.size() != 0) begin
            e = wb_q.pop_front();
            check("t5_wb_tag", dirty_tag_out, e.tag);
            check("t5_wb_blk", dirty_block_out, e.blk);
          end
          hs++;
        end
      end else begin
        wb_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    wb_ready = 1'b0;
    check("t5_no_timeout", cyc < 400, 1'b1);
    check("t5_handshakes", hs, 2);
    check("t5_done_pulses", dones, 1);
    check("t5_wb_left", wb_q.size(), 0);
    check("t5_idle_wb_valid", wb_valid, 1'b0);
    expect_miss("t5_inv_s0", 4'd0, 25'h0AAAA);
    expect_miss("t5_inv_s5w0", 4'd5, 25'h05550);
    expect_miss("t5_inv_s5w1", 4'd5, 25'h05551);
    expect_miss("t5_inv_s7", 4'd7, 25'h07770);

    // reset in the middle of a flush
    refill(4'd9, 25'h09990, a, 1'b1, 2'd0, 32'h99999999);
    refill(4'd1, 25'h01110, b, 1'b0, 2'd0, 32'h0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (10) tick();
    check("t6_busy_before", flush_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", flush_busy, 1'b0);
    check("t6_wb_valid", wb_valid, 1'b0);
    check("t6_done", flush_done, 1'b0);
    check("t6_data_out", data_out, 32'h0);
    expect_miss("t6_miss_s9", 4'd9, 25'h09990);
    expect_miss("t6_miss_s1", 4'd1, 25'h01110);
    tick();
    check("t6_still_idle", flush_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
